ucie_rdi_sb_requester: RTL and testbench

Link-layer end of the RDI sideband (lp_cfg/pl_cfg, 32-bit, credit-based) that faces the channel adapter. It queues 64-bit sideband messages from the local agent and serializes each one into two 32-bit beats on lp_cfg, gated by credits returned on pl_cfg_crd. It also reassembles incoming pl_cfg beats into 64-bit messages for the local agent, returning one lp_cfg_crd pulse per freed beat.

---
 rtl/ucie_rdi_sb_requester.sv | 190 +++++++++++++++++++
 tb/tb_ucie_rdi_sb_requester.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_rdi_sb_requester.sv
// Link-layer end of the RDI sideband: serializes queued 64-bit messages into credit-gated
// 32-bit lp_cfg beats, and reassembles pl_cfg beats into 64-bit messages for the local agent.
module ucie_rdi_sb_requester #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CRD_MAX  = 8,
  localparam int CW      = $clog2(CRD_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   tx_msg,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [31:0]   lp_cfg,
  output logic          lp_cfg_vld,
  input  logic          pl_cfg_crd,
  input  logic [31:0]   pl_cfg,
  input  logic          pl_cfg_vld,
  output logic          lp_cfg_crd,
  output logic [63:0]   rx_msg,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CW-1:0] crd_cnt,
  input  logic          err_clr,
  output logic          crd_err,
  output logic          rx_overflow
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int PW  = $clog2(2 * RX_DEPTH + 1);
  localparam logic [TAW:0]  TX_FULL  = (TAW + 1)'(TX_DEPTH);
  localparam logic [RAW:0]  RX_FULL  = (RAW + 1)'(RX_DEPTH);
  localparam logic [CW-1:0] CRD_INIT = CW'(CRD_MAX);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high;
  // ready never depends on valid, and valid/data hold until the transfer.

  // ---------------- TX message FIFO ----------------
  logic [63:0]    tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [TAW:0]   tx_cnt;
  logic [63:0]    tx_head;
  logic           tx_push, tx_pop;

  assign tx_ready = (tx_cnt != TX_FULL);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem[tx_rd];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_msg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + (TAW + 1)'(tx_push) - (TAW + 1)'(tx_pop);
    end
  end

  // ---------------- TX serializer FSM ----------------
  typedef enum logic [1:0] {IDLE, LO, HI} tx_state_t;
  tx_state_t   state_q, state_d;
  logic        launch, cfg_vld_d, crd_ok;
  logic [31:0] cfg_d;

  assign crd_ok = (crd_cnt >= CW'(2));

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    tx_pop    = 1'b0;
    cfg_d     = '0;
    cfg_vld_d = 1'b0;
    case (state_q)
      // HI has already popped its message, so the head here is the next one.
      IDLE, HI: begin
        if (tx_cnt != '0 && crd_ok) begin
          state_d   = LO;
          launch    = 1'b1;
          cfg_d     = tx_head[31:0];
          cfg_vld_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        state_d   = HI;
        tx_pop    = 1'b1;
        cfg_d     = tx_head[63:32];
        cfg_vld_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lp_cfg     <= '0;
      lp_cfg_vld <= 1'b0;
    end else begin
      state_q    <= state_d;
      lp_cfg     <= cfg_d;
      lp_cfg_vld <= cfg_vld_d;
    end
  end

  // ---------------- TX credits ----------------
  logic [CW:0] crd_sum;
  logic        crd_over;

  always_comb begin
    crd_sum = {1'b0, crd_cnt} + (CW + 1)'(pl_cfg_crd);
    if (launch) crd_sum = crd_sum - (CW + 1)'(2);
    crd_over = (crd_sum > (CW + 1)'(CRD_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crd_cnt <= CRD_INIT;
      crd_err <= 1'b0;
    end else begin
      crd_cnt <= crd_over ? CRD_INIT : crd_sum[CW-1:0];
      crd_err <= crd_over || (crd_err && !err_clr);
    end
  end

  // ---------------- RX reassembly and FIFO ----------------
  logic [63:0]    rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [RAW:0]   rx_cnt;
  logic           rx_phase, rx_odd, rx_push, rx_drop, rx_pop;
  logic [31:0]    rx_lo;

  assign rx_odd   = pl_cfg_vld && rx_phase;
  assign rx_push  = rx_odd && (rx_cnt != RX_FULL);
  assign rx_drop  = rx_odd && (rx_cnt == RX_FULL);
  assign rx_valid = (rx_cnt != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_msg   = rx_valid ? rx_mem[rx_rd] : '0;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= {pl_cfg, rx_lo};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_phase    <= 1'b0;
      rx_lo       <= '0;
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_cnt      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (pl_cfg_vld) rx_phase <= ~rx_phase;
      if (pl_cfg_vld && !rx_phase) rx_lo <= pl_cfg;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt      <= rx_cnt + (RAW + 1)'(rx_push) - (RAW + 1)'(rx_pop);
      rx_overflow <= rx_drop || (rx_overflow && !err_clr);
    end
  end

  // ---------------- RX credit return ----------------
  // Pops and drops both free two peer beats; pulses drain the pending count one per cycle.
  logic [PW-1:0] pend;
  logic [PW:0]   pend_avail;
  logic          crd_pulse_d;

  always_comb begin
    pend_avail  = {1'b0, pend} + (PW + 1)'({rx_pop, 1'b0}) + (PW + 1)'({rx_drop, 1'b0});
    crd_pulse_d = (pend_avail != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      lp_cfg_crd <= 1'b0;
    end else begin
      pend       <= PW'(pend_avail - (PW + 1)'(crd_pulse_d));
      lp_cfg_crd <= crd_pulse_d;
    end
  end

endmodule

// File: tb/tb_ucie_rdi_sb_requester.sv
// Bench for ucie_rdi_sb_requester: directed vectors, a queue-based reference model
// compared on every cycle, and literal expectations at the key points of each scenario.
module tb_ucie_rdi_sb_requester;
  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int CRD_MAX  = 8;
  localparam int CW       = $clog2(CRD_MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   tx_msg = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [31:0]   lp_cfg;
  logic          lp_cfg_vld;
  logic          pl_cfg_crd = 1'b0;
  logic [31:0]   pl_cfg = '0;
  logic          pl_cfg_vld = 1'b0;
  logic          lp_cfg_crd;
  logic [63:0]   rx_msg;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [CW-1:0] crd_cnt;
  logic          err_clr = 1'b0;
  logic          crd_err;
  logic          rx_overflow;

  ucie_rdi_sb_requester #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .CRD_MAX(CRD_MAX)) dut (
    .clk(clk), .rst(rst), .tx_msg(tx_msg), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .lp_cfg(lp_cfg), .lp_cfg_vld(lp_cfg_vld), .pl_cfg_crd(pl_cfg_crd), .pl_cfg(pl_cfg),
    .pl_cfg_vld(pl_cfg_vld), .lp_cfg_crd(lp_cfg_crd), .rx_msg(rx_msg), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .crd_cnt(crd_cnt), .err_clr(err_clr), .crd_err(crd_err),
    .rx_overflow(rx_overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int vld_seen = 0;
  int crd_seen = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tx_valid = 1'b0; pl_cfg_vld = 1'b0; pl_cfg_crd = 1'b0;
    rx_ready = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_txq[$];
  logic [63:0] exp_q[$];
  bit          started = 0;
  bit          m_lo_sent;
  logic [31:0] m_cfg;
  bit          m_vld;
  int          m_crd;
  bit          m_crd_err;
  bit          m_rx_phase;
  logic [31:0] m_rx_lo;
  int          m_pend;
  bit          m_lp_crd;
  bit          m_ovf;

  initial begin : model
    bit accept, launch, pop, drop, push, over;
    int c, avail;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_txq.delete(); exp_q.delete();
        m_lo_sent = 0; m_cfg = '0; m_vld = 0; m_crd = CRD_MAX; m_crd_err = 0;
        m_rx_phase = 0; m_rx_lo = '0; m_pend = 0; m_lp_crd = 0; m_ovf = 0;
        started = 1;
      end else if (started) begin
        accept = tx_valid && (m_txq.size() < TX_DEPTH);
        launch = 0;
        if (m_lo_sent) begin
          m_cfg = m_txq[0][63:32]; m_vld = 1; m_lo_sent = 0;
          void'(m_txq.pop_front());
        end else if (m_txq.size() > 0 && m_crd >= 2) begin
          m_cfg = m_txq[0][31:0]; m_vld = 1; m_lo_sent = 1; launch = 1;
        end else begin
          m_cfg = '0; m_vld = 0;
        end
        if (accept) m_txq.push_back(tx_msg);
        c = m_crd - (launch ? 2 : 0) + (pl_cfg_crd ? 1 : 0);
        over = (c > CRD_MAX);
        m_crd = over ? CRD_MAX : c;
        m_crd_err = over || (m_crd_err && !err_clr);

        pop  = rx_ready && (exp_q.size() > 0);
        drop = 0;
        push = 0;
        if (pl_cfg_vld) begin
          if (!m_rx_phase) m_rx_lo = pl_cfg;
          else if (exp_q.size() == RX_DEPTH) drop = 1;
          else push = 1;
        end
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({pl_cfg, m_rx_lo});
        if (pl_cfg_vld) m_rx_phase = !m_rx_phase;
        m_ovf = drop || (m_ovf && !err_clr);
        avail = m_pend + (pop ? 2 : 0) + (drop ? 2 : 0);
        m_lp_crd = (avail > 0);
        m_pend = avail - (m_lp_crd ? 1 : 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (started) begin
        chk("lp_cfg", lp_cfg, m_cfg);
        chk("lp_cfg_vld", lp_cfg_vld, m_vld);
        chk("tx_ready", tx_ready, m_txq.size() < TX_DEPTH);
        chk("crd_cnt", crd_cnt, m_crd);
        chk("crd_err", crd_err, m_crd_err);
        chk("rx_valid", rx_valid, exp_q.size() > 0);
        chk("rx_msg", rx_msg, exp_q.size() > 0 ? exp_q[0] : 64'h0);
        chk("rx_overflow", rx_overflow, m_ovf);
        chk("lp_cfg_crd", lp_cfg_crd, m_lp_crd);
        if (lp_cfg_vld === 1'b1) vld_seen++;
        if (lp_cfg_crd === 1'b1) crd_seen++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  logic [63:0] tx5 [5] = '{64'hAAAA0001_BBBB0001, 64'hAAAA0002_BBBB0002, 64'hAAAA0003_BBBB0003,
                           64'hAAAA0004_BBBB0004, 64'hAAAA0005_BBBB0005};
  logic [63:0] rx5 [5] = '{64'h20000000_10000000, 64'h20000001_10000001, 64'h20000002_10000002,
                           64'h20000003_10000003, 64'h20000004_10000004};

  initial begin : stim
    int base;
    logic [63:0] m;
    tick();
    chk("rst_vld", lp_cfg_vld, 0);
    chk("rst_cfg", lp_cfg, 0);
    chk("rst_crd", crd_cnt, 8);
    chk("rst_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_msg", rx_msg, 0);
    chk("rst_errs", {crd_err, rx_overflow, lp_cfg_crd}, 0);
    tick();
    rst = 1'b0;

    // Single message
    tx_msg = 64'hDEADBEEF_01234567; tx_valid = 1'b1;
    tick(); tx_valid = 1'b0;
    chk("t1_c1_vld", lp_cfg_vld, 0);
    tick();
    chk("t1_lo", lp_cfg, 32'h01234567);
    chk("t1_lo_vld", lp_cfg_vld, 1);
    chk("t1_crd", crd_cnt, 6);
    tick();
    chk("t1_hi", lp_cfg, 32'hDEADBEEF);
    chk("t1_hi_vld", lp_cfg_vld, 1);
    tick();
    chk("t1_c4_vld", lp_cfg_vld, 0);
    chk("t1_c4_crd", crd_cnt, 6);

    // Credit starvation
    do_reset();
    base = vld_seen;
    for (int i = 0; i < 5; i++) begin
      tx_msg = tx5[i]; tx_valid = 1'b1;
      for (int w = 0; w < 50 && !tx_ready; w++) tick();
      if (!tx_ready) begin n_total++; $display("FAIL t2_push_wait got=0 exp=1"); end
      tick();
    end
    tx_valid = 1'b0;
    repeat (9) tick();
    chk("t2_beats", vld_seen - base, 8);
    chk("t2_crd0", crd_cnt, 0);
    chk("t2_held_vld", lp_cfg_vld, 0);
    pl_cfg_crd = 1'b1; tick();
    tick(); pl_cfg_crd = 1'b0;
    chk("t2_wait_vld", lp_cfg_vld, 0);
    chk("t2_crd2", crd_cnt, 2);
    tick();
    m = tx5[4];
    chk("t2_lo5", lp_cfg, m[31:0]);
    chk("t2_lo5_vld", lp_cfg_vld, 1);
    tick();
    chk("t2_hi5", lp_cfg, m[63:32]);
    tick();
    chk("t2_end_vld", lp_cfg_vld, 0);

    // Credit overflow, err_clr, set-wins, and launch/return netting
    do_reset();
    pl_cfg_crd = 1'b1; tick(); pl_cfg_crd = 1'b0;
    chk("t3_sat", crd_cnt, 8);
    chk("t3_err", crd_err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_clr", crd_err, 0);
    pl_cfg_crd = 1'b1; err_clr = 1'b1; tick(); pl_cfg_crd = 1'b0; err_clr = 1'b0;
    chk("t3_setwins", crd_err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tx_msg = 64'h0BADF00D_CAFEF00D; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    pl_cfg_crd = 1'b1; tick(); pl_cfg_crd = 1'b0;
    chk("t3_net_crd", crd_cnt, 7);
    chk("t3_net_err", crd_err, 0);
    repeat (3) tick();

    // RX reassembly and credit return
    do_reset();
    pl_cfg = 32'h11111111; pl_cfg_vld = 1'b1; tick();
    pl_cfg = 32'h22222222;
    chk("t4_half_valid", rx_valid, 0);
    tick(); pl_cfg_vld = 1'b0;
    chk("t4_valid", rx_valid, 1);
    chk("t4_msg", rx_msg, 64'h22222222_11111111);
    base = crd_seen;
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    repeat (4) tick();
    chk("t4_pulses", crd_seen - base, 2);
    chk("t4_empty", rx_valid, 0);

    // RX overflow and drain
    do_reset();
    base = crd_seen;
    for (int i = 0; i < 5; i++) begin
      m = rx5[i];
      pl_cfg = m[31:0]; pl_cfg_vld = 1'b1; tick();
      pl_cfg = m[63:32]; tick();
    end
    pl_cfg_vld = 1'b0;
    repeat (4) tick();
    chk("t5_ovf", rx_overflow, 1);
    chk("t5_drop_pulses", crd_seen - base, 2);
    for (int i = 0; i < 4; i++) begin
      chk("t5_drain_msg", rx_msg, rx5[i]);
      rx_ready = 1'b1; tick();
    end
    rx_ready = 1'b0;
    repeat (12) tick();
    chk("t5_all_pulses", crd_seen - base, 10);
    chk("t5_empty", rx_valid, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_ovf_clr", rx_overflow, 0);

    // Reset mid-message
    do_reset();
    tx_msg = 64'h12345678_9ABCDEF0; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    tick();
    chk("t6_lo_vld", lp_cfg_vld, 1);
    chk("t6_lo", lp_cfg, 32'h9ABCDEF0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_vld", lp_cfg_vld, 0);
    chk("t6_crd", crd_cnt, 8);
    chk("t6_ready", tx_ready, 1);
    base = vld_seen;
    repeat (5) tick();
    chk("t6_no_hi", vld_seen - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
